seq_alu_hs: RTL and testbench

SEQ_ALU_HS -- requirements
Module: seq_alu_hs

---
 rtl/seq_alu_hs.sv | 146 ++++++++++++++
 tb/tb_seq_alu_hs.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_hs.sv
// rtl/seq_alu_hs.sv - sequential ALU with accumulator and valid/ready result queue
// Optional build macro SEQ_ALU_HS_FLAGS_EN stores zero/carry/ovf per queue entry.
module seq_alu_hs #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int SW = $clog2(WIDTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_LTU = 3'd7
    } op_e;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign op_a      = acc_sel ? acc : A;
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        res = '0;
        case (op_e'(opcode))
            OP_ADD: res = op_a + B;
            OP_SUB: res = op_a - B;
            OP_AND: res = op_a & B;
            OP_OR:  res = op_a | B;
            OP_XOR: res = op_a ^ B;
            OP_SHL: res = op_a << B[SW-1:0];
            OP_SHR: res = op_a >> B[SW-1:0];
            OP_LTU: res = {{(WIDTH-1){1'b0}}, (op_a < B)};
            default: res = '0;
        endcase
    end

    // Clear wins over the accept-load; the accepted op already used the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc_clr)
                acc <= '0;
            else if (push)
                acc <= res;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            q_data[wr_ptr] <= res;
    end

    assign C = out_valid ? q_data[rd_ptr] : '0;

`ifdef SEQ_ALU_HS_FLAGS_EN
    logic [WIDTH:0] wsum;
    logic [WIDTH:0] wdiff;
    logic [2:0]     res_flags;
    logic [2:0]     q_flags [DEPTH];
    logic [2:0]     head_flags;

    assign wsum  = {1'b0, op_a} + {1'b0, B};
    assign wdiff = {1'b0, op_a} - {1'b0, B};

    // Flag order: {zero, carry, ovf}; carry is borrow for SUB.
    always_comb begin
        res_flags    = '0;
        res_flags[2] = (res == '0);
        case (op_e'(opcode))
            OP_ADD: begin
                res_flags[1] = wsum[WIDTH];
                res_flags[0] = (op_a[WIDTH-1] == B[WIDTH-1]) && (wsum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_flags[1] = wdiff[WIDTH];
                res_flags[0] = (op_a[WIDTH-1] != B[WIDTH-1]) && (wdiff[WIDTH-1] != op_a[WIDTH-1]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            q_flags[wr_ptr] <= res_flags;
    end

    assign head_flags = out_valid ? q_flags[rd_ptr] : 3'b000;
    assign zero  = head_flags[2];
    assign carry = head_flags[1];
    assign ovf   = head_flags[0];
`else
    assign zero  = 1'b0;
    assign carry = 1'b0;
    assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu_hs.sv
// tb/tb_seq_alu_hs.sv - directed self-checking bench for seq_alu_hs (WIDTH=8, DEPTH=2)
module tb_seq_alu_hs;

`ifdef SEQ_ALU_HS_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [7:0] A;
    logic [7:0] B;
    logic       acc_sel;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] C;
    logic       zero;
    logic       carry;
    logic       ovf;

    int total  = 0;
    int passed = 0;

    seq_alu_hs #(.WIDTH(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .acc_sel  (acc_sel),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C        (C),
        .zero     (zero),
        .carry    (carry),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        opcode   = o;
        A        = a;
        B        = b;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; opcode = 3'd0; A = '0; B = '0;
        acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_c", C, 8'h00);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_zero", zero, 1'b0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // ADD with carry out
        op(3'd0, 8'hF0, 8'h20);
        cyc();
        in_valid = 1'b0;
        chk1("add_valid", out_valid, 1'b1);
        chk8("add_c", C, 8'h10);
        chk1("add_carry", carry, FL);
        chk1("add_ovf", ovf, 1'b0);
        cyc();
        chk1("add_drained", out_valid, 1'b0);
        chk8("add_drained_c", C, 8'h00);

        // SUB overflow then SUB to zero, back to back
        op(3'd1, 8'h80, 8'h01);
        cyc();
        chk8("sub1_c", C, 8'h7F);
        chk1("sub1_ovf", ovf, FL);
        chk1("sub1_carry", carry, 1'b0);
        op(3'd1, 8'h05, 8'h05);
        cyc();
        in_valid = 1'b0;
        chk1("sub2_valid", out_valid, 1'b1);
        chk8("sub2_c", C, 8'h00);
        chk1("sub2_zero", zero, FL);
        cyc();
        chk1("sub_drained", out_valid, 1'b0);

        // Backpressure: queue of two fills, third waits for a pop
        out_ready = 1'b0;
        op(3'd0, 8'h01, 8'h01);
        cyc();
        chk1("bp_ready1", in_ready, 1'b1);
        op(3'd0, 8'h02, 8'h02);
        cyc();
        chk1("bp_ready2", in_ready, 1'b0);
        chk8("bp_head", C, 8'h02);
        op(3'd0, 8'h03, 8'h03);
        cyc();
        chk1("bp_third_blocked", in_ready, 1'b0);
        chk8("bp_head_stable", C, 8'h02);
        out_ready = 1'b1;
        cyc();
        chk8("bp_pop2", C, 8'h04);
        chk1("bp_ready_after_pop", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk8("bp_third", C, 8'h06);
        cyc();
        chk1("bp_drained", out_valid, 1'b0);

        // Accumulate 3,6,9,12 then clear with simultaneous accept
        acc_clr = 1'b1;
        cyc();
        acc_clr = 1'b0;
        acc_sel = 1'b1;
        op(3'd0, 8'hAA, 8'h03);
        cyc();
        chk8("acc_1", C, 8'd3);
        cyc();
        chk8("acc_2", C, 8'd6);
        cyc();
        chk8("acc_3", C, 8'd9);
        cyc();
        chk8("acc_4", C, 8'd12);
        B = 8'h01;
        acc_clr = 1'b1;
        cyc();
        chk8("acc_clr_op", C, 8'd13);
        acc_clr = 1'b0;
        B = 8'h05;
        cyc();
        chk8("acc_after_clr", C, 8'd5);
        in_valid = 1'b0;
        acc_sel = 1'b0;
        cyc();

        // Shifts use only low log2(WIDTH) bits of B; LTU
        op(3'd5, 8'h01, 8'h0B);
        cyc();
        chk8("shl", C, 8'h08);
        op(3'd6, 8'h80, 8'h07);
        cyc();
        chk8("shr", C, 8'h01);
        op(3'd7, 8'h02, 8'hFE);
        cyc();
        chk8("ltu_true", C, 8'h01);
        chk1("ltu_carry", carry, 1'b0);
        op(3'd7, 8'hFE, 8'h02);
        cyc();
        in_valid = 1'b0;
        chk8("ltu_false", C, 8'h00);
        chk1("ltu_zero", zero, FL);
        op(3'd4, 8'h5A, 8'hFF);
        cyc();
        in_valid = 1'b0;
        chk8("xor", C, 8'hA5);
        cyc();

        // Reset with a full queue mid-stream
        out_ready = 1'b0;
        op(3'd0, 8'h09, 8'h09);
        cyc();
        op(3'd3, 8'h0F, 8'hF0);
        cyc();
        chk1("full_ready", in_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk8("mid_rst_c", C, 8'h00);
        chk1("mid_rst_ready", in_ready, 1'b1);
        cyc();
        chk1("rst_held_no_accept", out_valid, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        acc_sel = 1'b1;
        op(3'd0, 8'h01, 8'h01);
        cyc();
        chk8("post_rst_acc_sel", C, 8'h01);
        acc_sel = 1'b0;
        cyc();
        in_valid = 1'b0;
        chk8("post_rst_add", C, 8'h02);
        cyc();
        chk1("post_rst_drained", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
